mmio_access_arbiter: RTL and testbench

- Shares the single 8-port memory-mapped IO bank between two requesters: requester 0 (core memory backend) and requester 1 (debug/DMA master).
- Accepts one transaction at a time with a valid/ready handshake, drives the bank's address/data/write-enable for exactly one cycle, and returns a registered response.
- Uses round-robin arbitration on conflict.
- Sits between the requesters and the IO bank inside the memory subsystem.

---
 rtl/mmio_access_arbiter_pkg.sv | 19 +
 rtl/mmio_access_arbiter_rr_picker.sv | 16 +
 rtl/mmio_access_arbiter.sv | 119 +++++++++++
 tb/tb_mmio_access_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_access_arbiter_pkg.sv
// Shared types and constants for the MMIO bank arbiter.
package mmio_access_arbiter_pkg;

    localparam int unsigned MMIO_PORT_BITS = 3;
    localparam int unsigned MMIO_DATA_BITS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } MmioArbState_t;

    typedef struct packed {
        logic                      write;
        logic [MMIO_PORT_BITS-1:0] port;
        logic [MMIO_DATA_BITS-1:0] data;
    } MmioRequest_t;

endpackage

// File: rtl/mmio_access_arbiter_rr_picker.sv
// Two-way round-robin select: a lone valid wins, a conflict goes to the
// requester that was not granted last.
module mmio_rr_picker (
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = valids;
        if (valids == 2'b11) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mmio_access_arbiter.sv
// Arbitrates two requesters onto the single MMIO bank: one transaction at a
// time, one bank-access cycle, then a one-cycle registered response strobe.
module mmio_access_arbiter
    import mmio_access_arbiter_pkg::*;
#(
    parameter int unsigned PORT_BITS      = MMIO_PORT_BITS,
    parameter int unsigned ADDR_BITS      = 18,
    parameter bit          FIRST_PRIORITY = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0Valid,
    input  logic                 req0Write,
    input  logic [PORT_BITS-1:0] req0Port,
    input  logic [31:0]          req0Data,
    input  logic                 req1Valid,
    input  logic                 req1Write,
    input  logic [PORT_BITS-1:0] req1Port,
    input  logic [31:0]          req1Data,
    output logic                 req0Ready,
    output logic                 req1Ready,
    output logic                 rsp0Valid,
    output logic                 rsp1Valid,
    output logic [31:0]          rspData,
    output logic [ADDR_BITS-1:0] backendAddress,
    output logic [31:0]          rs2,
    output logic                 mmioWriteEnable,
    input  logic [31:0]          mmioDataOut
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_ACCESS  = 2'(ACCESS);
    localparam logic [1:0] ST_RESPOND = 2'(RESPOND);

    logic [1:0]           state_q;
    logic [1:0]           state_next;
    logic [1:0]           grant_c;
    logic                 in_idle_c;
    logic                 handshake_c;
    logic                 owner_q;
    logic                 last_grant_q;
    logic                 write_q;
    logic [PORT_BITS-1:0] port_q;
    logic [31:0]          data_q;
    logic [31:0]          rsp_data_q;

    mmio_rr_picker u_picker (
        .valids     ({req1Valid, req0Valid}),
        .last_grant (last_grant_q),
        .grant_c    (grant_c)
    );

    // Readys are gated by reset so they drop the instant reset rises.
    assign in_idle_c   = (state_q == ST_IDLE) && !reset;
    assign req0Ready   = in_idle_c & grant_c[0];
    assign req1Ready   = in_idle_c & grant_c[1];
    assign handshake_c = req0Ready | req1Ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:    if (handshake_c) state_next = ST_ACCESS;
            ST_ACCESS:  state_next = ST_RESPOND;
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Transaction capture on handshake and read-data capture during access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= !FIRST_PRIORITY;
            write_q      <= 1'b0;
            port_q       <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (handshake_c) begin
                owner_q      <= req1Ready;
                last_grant_q <= req1Ready;
                write_q      <= req1Ready ? req1Write : req0Write;
                port_q       <= req1Ready ? req1Port  : req0Port;
                data_q       <= req1Ready ? req1Data  : req0Data;
            end
            if (state_q == ST_ACCESS) begin
                rsp_data_q <= write_q ? 32'd0 : mmioDataOut;
            end
        end
    end

    always_comb begin
        backendAddress  = '0;
        rs2             = '0;
        mmioWriteEnable = 1'b0;
        rsp0Valid       = 1'b0;
        rsp1Valid       = 1'b0;
        if (state_q == ST_ACCESS) begin
            backendAddress  = ADDR_BITS'(port_q);
            rs2             = data_q;
            mmioWriteEnable = write_q;
        end
        if (state_q == ST_RESPOND) begin
            rsp0Valid = !owner_q;
            rsp1Valid = owner_q;
        end
    end

    assign rspData = rsp_data_q;

endmodule

// File: tb/tb_mmio_access_arbiter.sv
// Scoreboard bench for mmio_access_arbiter: a transaction-level model predicts
// grants, bank accesses and responses; a separate monitor compares them.
module tb_mmio_access_arbiter;

    typedef struct {
        int          due;
        logic        wr;
        logic [2:0]  port;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          due;
        logic        req;
        logic [31:0] data;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0Valid = 1'b0, req0Write = 1'b0;
    logic [2:0]  req0Port = 3'd0;
    logic [31:0] req0Data = 32'd0;
    logic        req1Valid = 1'b0, req1Write = 1'b0;
    logic [2:0]  req1Port = 3'd0;
    logic [31:0] req1Data = 32'd0;
    logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid, mmioWriteEnable;
    logic [31:0] rspData, rs2, mmioDataOut;
    logic [17:0] backendAddress;

    logic [31:0] env_bank [8] = '{default: 32'd0};
    logic [31:0] ref_bank [8] = '{default: 32'd0};

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [1:0]  ready_q[$];

    int          cyc = 0;
    int          next_free = 0;
    logic        m_last = 1'b1;
    logic [1:0]  m_exp;
    logic        m_g, m_w;
    logic [2:0]  m_p;
    logic [31:0] m_d, m_rd;

    int          n_pass = 0;
    int          n_checks = 0;
    logic [31:0] last_rsp = 32'd0;

    mmio_access_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .req0Valid       (req0Valid),
        .req0Write       (req0Write),
        .req0Port        (req0Port),
        .req0Data        (req0Data),
        .req1Valid       (req1Valid),
        .req1Write       (req1Write),
        .req1Port        (req1Port),
        .req1Data        (req1Data),
        .req0Ready       (req0Ready),
        .req1Ready       (req1Ready),
        .rsp0Valid       (rsp0Valid),
        .rsp1Valid       (rsp1Valid),
        .rspData         (rspData),
        .backendAddress  (backendAddress),
        .rs2             (rs2),
        .mmioWriteEnable (mmioWriteEnable),
        .mmioDataOut     (mmioDataOut)
    );

    always #5 clock = ~clock;

    // Behavioural IO bank: combinational read, write lands on the clock edge.
    assign mmioDataOut = env_bank[backendAddress[2:0]];
    always @(posedge clock) begin
        if (mmioWriteEnable) env_bank[backendAddress[2:0]] <= rs2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a new transaction may start 3 cycles after the previous;
    // lone valid wins, conflicts alternate away from the last winner.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            if (reset) begin
                next_free = cyc;
                m_last    = 1'b1;
                for (int i = 0; i < 8; i++) ref_bank[i] = env_bank[i];
            end else begin
                m_exp = 2'b00;
                if (cyc >= next_free && (req0Valid || req1Valid)) begin
                    m_g = (req0Valid && req1Valid) ? ~m_last : req1Valid;
                    m_exp[m_g] = 1'b1;
                    m_w  = m_g ? req1Write : req0Write;
                    m_p  = m_g ? req1Port  : req0Port;
                    m_d  = m_g ? req1Data  : req0Data;
                    m_rd = m_w ? 32'd0 : ref_bank[m_p];
                    if (m_w) ref_bank[m_p] = m_d;
                    acc_q.push_back('{cyc + 1, m_w, m_p, m_d});
                    rsp_q.push_back('{cyc + 2, m_g, m_rd});
                    next_free = cyc + 3;
                    m_last    = m_g;
                end
                ready_q.push_back(m_exp);
            end
        end
    end

    // Monitor: compares DUT outputs against the model's queued expectations.
    initial begin
        acc_t a;
        rsp_t r;
        logic [1:0] e;
        forever begin
            @(negedge clock or posedge reset);
            if (reset) begin
                #1;
                chk("rst_ready",  32'({req1Ready, req0Ready}), 32'd0);
                chk("rst_rsp",    32'({rsp1Valid, rsp0Valid}), 32'd0);
                chk("rst_we",     32'(mmioWriteEnable), 32'd0);
                chk("rst_addr",   32'(backendAddress), 32'd0);
                chk("rst_wdata",  rs2, 32'd0);
                chk("rst_rdata",  rspData, 32'd0);
                ready_q.delete();
                acc_q.delete();
                rsp_q.delete();
                last_rsp = 32'd0;
            end else begin
                if (ready_q.size() == 0) begin
                    chk("ready_expect_present", 32'(ready_q.size()), 32'd1);
                end else begin
                    e = ready_q.pop_front();
                    chk("ready", 32'({req1Ready, req0Ready}), 32'(e));
                end
                if (acc_q.size() != 0 && acc_q[0].due == cyc) begin
                    a = acc_q.pop_front();
                    chk("bank_we",    32'(mmioWriteEnable), 32'(a.wr));
                    chk("bank_addr",  32'(backendAddress), 32'(a.port));
                    chk("bank_wdata", rs2, a.data);
                end else begin
                    chk("idle_we",    32'(mmioWriteEnable), 32'd0);
                    chk("idle_addr",  32'(backendAddress), 32'd0);
                    chk("idle_wdata", rs2, 32'd0);
                end
                if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
                    r = rsp_q.pop_front();
                    chk("rsp0Valid", 32'(rsp0Valid), 32'(!r.req));
                    chk("rsp1Valid", 32'(rsp1Valid), 32'(r.req));
                    chk("rspData",   rspData, r.data);
                    last_rsp = r.data;
                end else begin
                    chk("rsp_quiet", 32'({rsp1Valid, rsp0Valid}), 32'd0);
                    chk("rsp_hold",  rspData, last_rsp);
                end
            end
        end
    end

    task automatic step(input logic v0, input logic w0, input logic [2:0] p0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [2:0] p1, input logic [31:0] d1);
        @(posedge clock);
        #1;
        req0Valid = v0; req0Write = w0; req0Port = p0; req0Data = d0;
        req1Valid = v1; req1Write = w1; req1Port = p1; req1Data = d1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Lone write, then a lone read of a preloaded port.
        step(1, 1, 3'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 3'd2, 32'h12345678, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 3'd2, 32'hFFFF0000);
        idle(3);

        // Both valid continuously: grants alternate starting with requester 0.
        for (int i = 0; i < 12; i++) step(1, 0, 3'd5, 32'h1, 1, 0, 3'd2, 32'h2);
        idle(3);

        // Requester 1 arrives while requester 0 is in flight.
        step(1, 0, 3'd5, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 3'd7, 32'hCAFE0001);
        idle(3);

        // Single requester back-to-back with valid held.
        for (int i = 0; i < 9; i++) step(1, 0, 3'(i), 32'h0, 0, 0, 0, 0);
        idle(3);

        // Randomised traffic, including valids dropped before a handshake.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 1'($urandom), 3'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, 1'($urandom), 3'($urandom), $urandom);
        end
        idle(3);

        // Reset during the access cycle of a write; then an immediate conflict.
        step(1, 1, 3'd6, 32'hA5A5A5A5, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        req0Valid = 1'b0;
        #2 reset = 1'b1;
        step(1, 0, 3'd6, 32'h0, 1, 0, 3'd5, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 9; i++) step(1, 0, 3'd6, 32'h0, 1, 0, 3'd5, 32'h0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
